// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp
//  Purpose  : Multi-ported register file with a per-register busy scoreboard.
//             Registered reads (1-cycle latency) see the writes and reserves
//             of the same edge (write-through bypass). The highest-index
//             write port wins on an address collision, and a reserve beats a
//             write to the same register. Register 0 can be hardwired to zero.
//  Ports    : clk        - clock, all state updates on the rising edge
//             rst        - synchronous active-high reset
//             raddr      - NREAD read addresses, port k in slice k
//             rdata      - NREAD registered read data words
//             rbusy      - NREAD registered busy flags for the read addresses
//             wen        - NWRITE write enables
//             waddr      - NWRITE write addresses
//             wdata      - NWRITE write data words
//             resv_en    - reserve request (marks resv_addr as pending)
//             resv_addr  - register to reserve
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter  int DATAWIDTH = 32,
    parameter  int REGCOUNT  = 32,
    parameter  int NREAD     = 2,
    parameter  int NWRITE    = 2,
    parameter  int ZERO_REG  = 1,
    localparam int AW        = (REGCOUNT > 2) ? $clog2(REGCOUNT) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREAD*AW-1:0]         raddr,
    output logic [NREAD*DATAWIDTH-1:0]  rdata,
    output logic [NREAD-1:0]            rbusy,
    input  logic [NWRITE-1:0]           wen,
    input  logic [NWRITE*AW-1:0]        waddr,
    input  logic [NWRITE*DATAWIDTH-1:0] wdata,
    input  logic                        resv_en,
    input  logic [AW-1:0]               resv_addr
);

    // Storage covers the full address space so that every address decodes to
    // an entry. Entries at or above REGCOUNT are forced to zero each cycle;
    // this discards out-of-range writes/reserves and makes out-of-range reads
    // return 0 / not-busy without any address comparators. Those entries are
    // constant and disappear in synthesis.
    localparam int C_DEPTH = 1 << AW;

    logic [DATAWIDTH-1:0] r_regs     [C_DEPTH];
    logic [C_DEPTH-1:0]   r_busy;
    logic [DATAWIDTH-1:0] w_regs_nxt [C_DEPTH];
    logic [C_DEPTH-1:0]   w_busy_nxt;

    // Next state of the whole file after this edge's writes and reserve.
    // Reads sample this next state, which gives the write-through bypass.
    always_comb begin
        for (int i = 0; i < C_DEPTH; i++) begin
            w_regs_nxt[i] = r_regs[i];
        end
        w_busy_nxt = r_busy;

        // Ascending port order: a later (higher-index) port overrides.
        for (int p = 0; p < NWRITE; p++) begin
            if (wen[p]) begin
                w_regs_nxt[waddr[p*AW +: AW]] = wdata[p*DATAWIDTH +: DATAWIDTH];
                w_busy_nxt[waddr[p*AW +: AW]] = 1'b0;
            end
        end

        // Applied after the writes so a reserve wins over a same-cycle write.
        if (resv_en) begin
            w_busy_nxt[resv_addr] = 1'b1;
        end

        for (int i = REGCOUNT; i < C_DEPTH; i++) begin
            w_regs_nxt[i] = '0;
            w_busy_nxt[i] = 1'b0;
        end

        if (ZERO_REG != 0) begin
            w_regs_nxt[0] = '0;
            w_busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < C_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
            rdata  <= '0;
            rbusy  <= '0;
        end else begin
            for (int i = 0; i < C_DEPTH; i++) begin
                r_regs[i] <= w_regs_nxt[i];
            end
            r_busy <= w_busy_nxt;
            for (int k = 0; k < NREAD; k++) begin
                rdata[k*DATAWIDTH +: DATAWIDTH] <= w_regs_nxt[raddr[k*AW +: AW]];
                rbusy[k]                        <= w_busy_nxt[raddr[k*AW +: AW]];
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The module SHALL have parameter DATAWIDTH, default 32, meaning the bit width of each register.
REQ-002 The module SHALL have parameter REGCOUNT, default 32, meaning the number of registers (range 2..64).
REQ-003 The module SHALL have parameter NREAD, default 2, meaning the number of read ports (range 1..4).
REQ-004 The module SHALL have parameter NWRITE, default 2, meaning the number of write ports (range 1..2).
REQ-005 The module SHALL have parameter ZERO_REG, default 1, meaning that 1 hardwires register 0 to zero.
REQ-006 Address width AW SHALL be the local value clog2(REGCOUNT), with a minimum of 1.
REQ-007 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-008 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 Port raddr, input, NREAD*AW bits: read addresses, with port k occupying slice k.
REQ-010 Port rdata, output, NREAD*DATAWIDTH bits: registered read data, with port k occupying slice k.
REQ-011 Port rbusy, output, NREAD bits: registered scoreboard busy flag for each read address.
REQ-012 Port wen, input, NWRITE bits: per-port write enable.
REQ-013 Port waddr, input, NWRITE*AW bits: write addresses.
REQ-014 Port wdata, input, NWRITE*DATAWIDTH bits: write data.
REQ-015 Port resv_en, input, 1 bit: reserve request, which marks a destination register as pending.
REQ-016 Port resv_addr, input, AW bits: the register to reserve.

Function
REQ-017 Reads SHALL have a latency of 1 cycle: rdata[k] after edge N SHALL equal the value register raddr[k] holds once edge N's writes are applied (write-through bypass).
REQ-018 When several enabled write ports target the same address in one cycle, the highest-index port SHALL win, for both storage and bypass.
REQ-019 When ZERO_REG=1, writes to address 0 SHALL be discarded, reads of address 0 SHALL return 0 (including bypass), and register 0 SHALL never be busy.
REQ-020 Any write or reserve to an address >= REGCOUNT SHALL be ignored, and a read of such an address SHALL return 0 with rbusy=0.
REQ-021 The scoreboard SHALL hold one busy bit per register.
REQ-022 An asserted resv_en SHALL set busy[resv_addr] at the edge.
REQ-023 An enabled write SHALL clear the busy bit of its address at the edge.
REQ-024 When a reserve and a write target the same address in the same cycle, the reserve SHALL win and the bit SHALL remain set.
REQ-025 rbusy[k] after edge N SHALL equal busy[raddr[k]] after edge N's updates, using the same bypass rule as data.
REQ-026 Reserving an already-busy register SHALL keep it busy without error.
REQ-027 A write to a non-busy register SHALL be legal; it SHALL update the data and leave the busy bit at 0.
REQ-028 The module SHALL contain no combinational path from any input to rdata or rbusy.

Reset
REQ-029 While rst=1 at an edge, all registers, all busy bits, rdata and rbusy SHALL become 0, and writes and reserves in that cycle SHALL be discarded.
REQ-030 The first edge with rst=0 SHALL operate normally, with no extra cycles of delay.
REQ-031 Asserting rst mid-operation SHALL clear all pending reservations.

Verification
REQ-032 The bench SHALL cover: after reset, write port 0 puts 0xDEADBEEF into r5, raddr[0]=5 in the same cycle -> rdata[0]=0xDEADBEEF at the next edge and stays there on later reads.
REQ-033 The bench SHALL cover: both write ports target r7 with 0x11 (port 0) and 0x22 (port 1) -> r7 reads 0x22, including on the bypassed read in the same cycle.
REQ-034 The bench SHALL cover: with ZERO_REG=1, write 0xFFFFFFFF to r0 -> rdata reads 0 on the bypass cycle and afterwards; resv_en to r0 -> rbusy stays 0.
REQ-035 The bench SHALL cover: reserve r3 -> rbusy=1 next cycle; then a write to r3 plus a reserve of r3 in the same cycle -> still busy; a write to r3 alone -> rbusy=0 in the bypass cycle.
REQ-036 The bench SHALL cover: fill r1..r31 with nonzero data, reserve r9, assert rst for 1 cycle -> every read returns 0 and every rbusy is 0 from the next edge.
REQ-037 The bench SHALL cover: REGCOUNT=24, write to address 30 -> ignored, and a read of address 30 returns 0.
